// File: rtl/delay_line_arbiter_pkg.sv
// Shared constants and helpers for the delay-line arbiter slice.
package delay_line_arbiter_pkg;

    // Fixed latency of the shared delay datapath, in clock cycles.
    localparam int DLY_LAT = 3;

    // Width of a requester ID for n requesters (at least one bit).
    function automatic int id_width(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/delay_line_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index after last_ptr.
module delay_line_arbiter_rr_pick
    import delay_line_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] eligible,
    input  logic [IDW-1:0]  last_ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    logic found_s;
    int   pos_s;

    // Scan NREQ positions starting just after last_ptr, wrapping at NREQ.
    always_comb begin
        gnt     = '0;
        idx     = '0;
        found_s = 1'b0;
        pos_s   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            pos_s = (int'(last_ptr) + k) % NREQ;
            if (!found_s && eligible[pos_s]) begin
                found_s    = 1'b1;
                gnt[pos_s] = 1'b1;
                idx        = IDW'(pos_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/design_delay.sv
// Fixed-latency sample delay: DLY_LAT register stages with no reset.
module design_delay
    import delay_line_arbiter_pkg::*;
#(
    parameter int Nbits = 2
) (
    input  logic           clk,
    input  logic [Nbits:0] SIG_IN,
    output logic [Nbits:0] SIG_OUT
);

    logic [Nbits:0] stage_r [DLY_LAT];

    // Shift the sample one stage per clock; contents are qualified downstream.
    always_ff @(posedge clk) begin
        stage_r[0] <= SIG_IN;
        for (int i = 1; i < DLY_LAT; i++) begin
            stage_r[i] <= stage_r[i-1];
        end
    end

    assign SIG_OUT = stage_r[DLY_LAT-1];

endmodule

// File: rtl/delay_line_arbiter.sv
// Round-robin arbiter feeding one shared 3-cycle delay pipe, with a
// valid/ID sideband kept in lock-step so each output is tagged.
module delay_line_arbiter
    import delay_line_arbiter_pkg::*;
#(
    parameter int NBITS = 2,
    parameter int NREQ  = 4,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*(NBITS+1)-1:0] req_data,
    input  logic [NREQ-1:0]         req_mask,
    input  logic                    hold,
    output logic [NREQ-1:0]         gnt,
    output logic                    out_valid,
    output logic [IDW-1:0]          out_id,
    output logic [NBITS:0]          out_data,
    output logic                    busy
);

    logic [NREQ-1:0] eligible_s;
    logic [NREQ-1:0] gnt_s;
    logic [IDW-1:0]  idx_s;
    logic [IDW-1:0]  last_ptr_r;
    logic [NBITS:0]  sig_in_s;
    logic [NBITS:0]  delay_out_s;
    logic            in_flight_s;
    logic            vld_pipe_r [DLY_LAT];
    logic [IDW-1:0]  id_pipe_r  [DLY_LAT];

    // No grants while held or while reset is asserted.
    assign eligible_s = req & req_mask & {NREQ{~hold}} & {NREQ{~rst}};

    delay_line_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .eligible (eligible_s),
        .last_ptr (last_ptr_r),
        .gnt      (gnt_s),
        .idx      (idx_s)
    );

    assign gnt = gnt_s;

    // Launch mux: granted requester's sample, zero when idle.
    always_comb begin
        if (|gnt_s) begin
            sig_in_s = req_data[int'(idx_s) * (NBITS + 1) +: (NBITS + 1)];
        end else begin
            sig_in_s = '0;
        end
    end

    design_delay #(
        .Nbits (NBITS)
    ) u_delay (
        .clk     (clk),
        .SIG_IN  (sig_in_s),
        .SIG_OUT (delay_out_s)
    );

    // Sideband pipe and RR pointer; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DLY_LAT; i++) begin
                vld_pipe_r[i] <= 1'b0;
                id_pipe_r[i]  <= '0;
            end
            last_ptr_r <= IDW'(NREQ - 1);
        end else begin
            vld_pipe_r[0] <= |gnt_s;
            id_pipe_r[0]  <= idx_s;
            for (int i = 1; i < DLY_LAT; i++) begin
                vld_pipe_r[i] <= vld_pipe_r[i-1];
                id_pipe_r[i]  <= id_pipe_r[i-1];
            end
            if (|gnt_s) begin
                last_ptr_r <= idx_s;
            end else begin
                last_ptr_r <= last_ptr_r;
            end
        end
    end

    // Any valid stage, including the output stage, counts as in flight.
    always_comb begin
        in_flight_s = 1'b0;
        for (int i = 0; i < DLY_LAT; i++) begin
            in_flight_s = in_flight_s | vld_pipe_r[i];
        end
    end

    assign out_valid = vld_pipe_r[DLY_LAT-1];
    assign out_id    = id_pipe_r[DLY_LAT-1];
    assign out_data  = delay_out_s & {(NBITS + 1){out_valid}};
    assign busy      = (|eligible_s) | in_flight_s;

endmodule

// File: tb/tb_delay_line_arbiter.sv
// Self-checking bench for delay_line_arbiter with a queue-based model.
module tb_delay_line_arbiter;

    localparam int NBITS = 2;
    localparam int NREQ  = 4;
    localparam int W     = NBITS + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req;
    logic [11:0]     req_data;
    logic [3:0]      req_mask;
    logic            hold;
    logic [3:0]      gnt;
    logic            out_valid;
    logic [1:0]      out_id;
    logic [2:0]      out_data;
    logic            busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int cyc;
        int id;
        int data;
    } launch_t;

    launch_t m_q[$];
    int      m_last = NREQ - 1;
    int      m_cyc  = 0;

    delay_line_arbiter #(.NBITS(NBITS), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .req_mask  (req_mask),
        .hold      (hold),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pack(input int d0, d1, d2, d3);
        return {3'(d3), 3'(d2), 3'(d1), 3'(d0)};
    endfunction

    function automatic logic [3:0] elig_now();
        if (rst) return 4'b0000;
        return req & req_mask & {4{~hold}};
    endfunction

    function automatic int model_pick();
        logic [3:0] e;
        e = elig_now();
        for (int k = 1; k <= NREQ; k++) begin
            if (e[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_gnt();
        int p;
        p = model_pick();
        return (p < 0) ? 4'b0000 : 4'(1 << p);
    endfunction

    // Expected {valid, id, data} for the current cycle.
    function automatic logic [5:0] model_out();
        if (m_q.size() > 0 && m_q[0].cyc == m_cyc - 3)
            return {1'b1, 2'(m_q[0].id), 3'(m_q[0].data)};
        return 6'b000000;
    endfunction

    function automatic logic model_busy();
        return (elig_now() != 4'b0000) || (m_q.size() > 0);
    endfunction

    task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] m,
                         input logic h, input logic [11:0] d);
        @(negedge clk);
        rst = r; req = rq; req_mask = m; hold = h; req_data = d;
        #1;
    endtask

    task automatic commit();
        int p;
        p = model_pick();
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_last = NREQ - 1;
        end else begin
            if (m_q.size() > 0 && m_q[0].cyc == m_cyc - 3) void'(m_q.pop_front());
            if (p >= 0) begin
                m_q.push_back('{m_cyc, p, int'((req_data >> (p * W)) & 12'h007)});
                m_last = p;
            end
        end
        m_cyc++;
    endtask

    task automatic test_reset();
        drive(1'b1, 4'hF, 4'hF, 1'b0, pack(1, 2, 3, 4));
        total++;
        if (gnt !== 4'b0000) begin
            bad++; $display("FAIL reset_gnt0 got=%b want=0000", gnt);
        end
        commit();
        drive(1'b1, 4'hF, 4'hF, 1'b0, pack(1, 2, 3, 4));
        total++;
        if ({gnt, out_valid, out_data} !== 8'h00) begin
            bad++; $display("FAIL reset_state got gnt=%b v=%b d=%0d want 0", gnt, out_valid, out_data);
        end
        commit();
        drive(1'b0, 4'hF, 4'hF, 1'b0, pack(1, 2, 3, 4));
        total++;
        if (gnt !== 4'b0001) begin
            bad++; $display("FAIL reset_first_gnt got=%b want=0001", gnt);
        end
        commit();
        drive(1'b1, 4'h0, 4'hF, 1'b0, 12'h000);
        commit();
    endtask

    task automatic test_rr_all();
        for (int c = 0; c < 9; c++) begin
            drive(1'b0, (c < 5) ? 4'hF : 4'h0, 4'hF, 1'b0, pack(1, 2, 3, 4));
            total++;
            if (gnt !== model_gnt()) begin
                bad++; $display("FAIL rr_gnt c=%0d got=%b want=%b", c, gnt, model_gnt());
            end
            total++;
            if ({out_valid, out_id, out_data} !== model_out()) begin
                bad++; $display("FAIL rr_out c=%0d got=%b want=%b", c, {out_valid, out_id, out_data}, model_out());
            end
            commit();
        end
    endtask

    task automatic test_single();
        int pulses = 0;
        for (int c = 0; c < 9; c++) begin
            drive(1'b0, (c < 5) ? 4'b0100 : 4'b0000, 4'hF, 1'b0, pack(0, 0, 5, 0));
            total++;
            if (gnt !== model_gnt() || (c < 5 && gnt !== 4'b0100)) begin
                bad++; $display("FAIL single_gnt c=%0d got=%b want=%b", c, gnt, model_gnt());
            end
            total++;
            if ({out_valid, out_id, out_data} !== model_out()) begin
                bad++; $display("FAIL single_out c=%0d got=%b want=%b", c, {out_valid, out_id, out_data}, model_out());
            end
            if (out_valid === 1'b1 && out_id === 2'd2) pulses++;
            commit();
        end
        total++;
        if (pulses != 5) begin
            bad++; $display("FAIL single_pulses got=%0d want=5", pulses);
        end
    endtask

    task automatic test_mask();
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, (c < 6) ? 4'hF : 4'h0, 4'b1010, 1'b0, pack(6, 7, 2, 3));
            total++;
            if (gnt !== model_gnt() || (gnt & 4'b0101) !== 4'b0000) begin
                bad++; $display("FAIL mask_gnt c=%0d got=%b want=%b", c, gnt, model_gnt());
            end
            total++;
            if ({out_valid, out_id, out_data} !== model_out()) begin
                bad++; $display("FAIL mask_out c=%0d got=%b want=%b", c, {out_valid, out_id, out_data}, model_out());
            end
            commit();
        end
    endtask

    task automatic test_hold();
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, (c < 8) ? 4'b1011 : 4'h0, 4'hF, (c >= 2 && c <= 4), pack(1, 4, 0, 7));
            total++;
            if (gnt !== model_gnt() || (hold && gnt !== 4'b0000)) begin
                bad++; $display("FAIL hold_gnt c=%0d got=%b want=%b", c, gnt, model_gnt());
            end
            total++;
            if ({out_valid, out_id, out_data, busy} !== {model_out(), model_busy()}) begin
                bad++; $display("FAIL hold_out c=%0d got=%b want=%b", c,
                                {out_valid, out_id, out_data, busy}, {model_out(), model_busy()});
            end
            commit();
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 6; c++) begin
            drive(c == 1, (c == 0) ? 4'b0010 : 4'h0, 4'hF, 1'b0, pack(0, 5, 0, 0));
            total++;
            if ({out_valid, out_id, out_data, busy, gnt} !== {model_out(), model_busy(), model_gnt()}) begin
                bad++; $display("FAIL rstmid c=%0d got=%b want=%b", c,
                                {out_valid, out_id, out_data, busy, gnt}, {model_out(), model_busy(), model_gnt()});
            end
            commit();
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom_range(0, 39) == 0), 4'($urandom), 4'($urandom | $urandom),
                  ($urandom_range(0, 5) == 0), 12'($urandom));
            total++;
            if (gnt !== model_gnt()) begin
                bad++; $display("FAIL rand_gnt c=%0d got=%b want=%b", c, gnt, model_gnt());
            end
            total++;
            if ({out_valid, out_id, out_data, busy} !== {model_out(), model_busy()}) begin
                bad++; $display("FAIL rand_out c=%0d got=%b want=%b", c,
                                {out_valid, out_id, out_data, busy}, {model_out(), model_busy()});
            end
            commit();
        end
    endtask

    initial begin
        rst = 1'b1; req = 4'h0; req_mask = 4'hF; hold = 1'b0; req_data = 12'h000;
        test_reset();
        test_rr_all();
        test_single();
        test_mask();
        test_hold();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
